// File: rtl/mem_pkg.sv
// Shared memory-access types for mem_pipe and future cache/bus blocks.
// Covers the access size encoding, request/response structs and fault classification.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } mem_size_t;

  typedef struct packed {
    logic        write;
    mem_size_t   size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } mem_rsp_t;

  // A request faults when it is misaligned for its size, uses the reserved
  // size, or addresses beyond the 2**addr_w byte storage.
  function automatic logic mem_fault(input mem_size_t size, input logic [31:0] addr,
                                     input int addr_w);
    logic misaligned;
    case (size)
      HALF:    misaligned = addr[0];
      WORD:    misaligned = (addr[1:0] != 2'b00);
      RSVD:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
    return misaligned || ((addr >> addr_w) != 32'd0);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension, purely combinational.
// Selects the addressed byte/half from a little-endian word.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[8*offset +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    data     = '0;
    case (size)
      BYTE:    data = {{24{sel_byte[7] & ~is_unsigned}}, sel_byte};
      HALF:    data = {{16{sel_half[15] & ~is_unsigned}}, sel_half};
      WORD:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_pipe.sv
// Pipelined byte-addressable memory with READ_LAT-cycle responses and a preload port.
// Stores commit at the accept edge; loads read the array at the accept edge.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  input  logic        setup_write,
  input  logic [31:0] setup_address,
  input  logic [31:0] setup_data_in
);

  localparam int WORDS = 1 << (ADDR_W - 2);

  // Per-stage control; the read word travels alongside in a separate data pipe.
  typedef struct packed {
    logic       valid;
    logic       fault;
    logic       write;
    mem_size_t  size;
    logic       is_unsigned;
    logic [1:0] offset;
  } stage_t;

  mem_req_t            req;
  mem_rsp_t            rsp;
  stage_t              stg [READ_LAT];
  stage_t              last;
  logic                ready_en;
  logic                stall;
  logic                accept;
  logic                req_fault;
  logic                setup_we;
  logic [3:0]          st_be;
  logic [31:0]         st_data;
  logic [ADDR_W-3:0]   word_idx;
  logic [ADDR_W-3:0]   setup_idx;
  logic [31:0]         mem [WORDS];
  logic [31:0]         rd_word;
  logic [31:0]         final_word;
  logic [31:0]         aligned;
  logic                unused_setup;

  assign req = '{write: req_write, size: mem_size_t'(req_size), is_unsigned: req_unsigned,
                 addr: req_addr, wdata: req_wdata};

  // req and rsp use valid/ready: a transfer happens on a rising clock edge
  // where both are 1; valid never waits on ready, and a stalled output
  // freezes every stage so rsp_* hold steady until consumed.
  assign last      = stg[READ_LAT-1];
  assign stall     = last.valid && !rsp_ready;
  assign req_ready = ready_en && !stall;
  assign accept    = req_valid && req_ready;
  assign req_fault = mem_fault(req.size, req.addr, ADDR_W);
  assign word_idx  = req.addr[ADDR_W-1:2];
  assign setup_idx = setup_address[ADDR_W-1:2];
  assign setup_we  = setup_write && !reset;
  assign unused_setup = ^{setup_address[31:ADDR_W], setup_address[1:0]};

  always_comb begin
    st_be   = 4'b0000;
    st_data = req.wdata;
    case (req.size)
      BYTE: begin
        st_be   = 4'b0001 << req.addr[1:0];
        st_data = {4{req.wdata[7:0]}};
      end
      HALF: begin
        st_be   = 4'b0011 << req.addr[1:0];
        st_data = {2{req.wdata[15:0]}};
      end
      WORD:    st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
    if (!accept || !req.write || req_fault) st_be = 4'b0000;
  end

  // Word array with byte-lane enables; contents survive reset.
  always_ff @(posedge clock) begin
    if (setup_we) begin
      mem[setup_idx] <= setup_data_in;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    if (accept) rd_word <= mem[word_idx];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) stg[i] <= '0;
    end else begin
      ready_en <= 1'b1;
      if (!stall) begin
        stg[0] <= '{valid: accept, fault: req_fault, write: req.write, size: req.size,
                    is_unsigned: req.is_unsigned, offset: req.addr[1:0]};
        for (int i = 1; i < READ_LAT; i++) stg[i] <= stg[i-1];
      end
    end
  end

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign final_word = rd_word;
    end else begin : g_latn
      logic [31:0] wd [READ_LAT-1];
      always_ff @(posedge clock) begin
        if (!stall) begin
          wd[0] <= rd_word;
          for (int i = 1; i < READ_LAT - 1; i++) wd[i] <= wd[i-1];
        end
      end
      assign final_word = wd[READ_LAT-2];
    end
  endgenerate

  mem_load_align u_align (
    .word        (final_word),
    .offset      (last.offset),
    .size        (last.size),
    .is_unsigned (last.is_unsigned),
    .data        (aligned)
  );

  always_comb begin
    rsp = '0;
    if (last.valid) begin
      rsp.fault = last.fault;
      if (!last.fault && !last.write) rsp.rdata = aligned;
    end
  end

  assign rsp_valid = last.valid;
  assign rsp_rdata = rsp.rdata;
  assign rsp_fault = rsp.fault;

endmodule
